// File: rtl/clk_lock_monitor_pkg.sv
// Shared constants for the clock lock monitor:
// FSM encoding, register map and CTRL bit positions.
package clk_lock_monitor_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_SETTLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_FAULT     = 2'd3;

  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_LOSS_CNT = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_IRQ      = 2'd3;

  localparam int CTRL_IRQ_EN     = 0;
  localparam int CTRL_RECOVER    = 1;
  localparam int CTRL_FORCE_HOLD = 2;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clk_lock_monitor_lock_sync.sv
// Two-flop synchroniser per lock bit plus
// registered previous value for falling-edge detect.
module lock_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] lk_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lk_o   = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/clk_lock_monitor.sv
// Wishbone lock supervisor: settle sequencing,
// per-source loss counters and maskable loss IRQ.
module clk_lock_monitor
  import clk_lock_monitor_pkg::*;
#(
  parameter int N_LOCK        = 3,
  parameter int STABLE_CYCLES = 1024,
  parameter int AUTO_RECOVER  = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [N_LOCK-1:0] lock_async_i,
  input  logic [1:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              sys_ready_o,
  output logic              ddr2_hold_o,
  output logic              irq_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(STABLE_CYCLES - 1);

  logic [N_LOCK-1:0] lk;
  logic [N_LOCK-1:0] fall;
  logic              all_lk;

  lock_sync #(.W(N_LOCK)) u_sync (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .async_i (lock_async_i),
    .lk_o    (lk),
    .fall_o  (fall)
  );

  assign all_lk = &lk;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          ack_q, ack_d;
  logic          irq_q, irq_d;
  logic          irq_en_q, irq_en_d;
  logic          hold_q, hold_d;
  logic [N_LOCK-1:0][7:0] loss_q, loss_d;

  logic bus_ack, wr;
  logic wr_loss, wr_ctrl, wr_irq;
  logic recover, set_irq;
  logic [31:0] rdata;
  logic unused_dat;

  // A dropped cyc/stb kills an ack already in flight.
  assign bus_ack = ack_q & wb_cyc_i & wb_stb_i;
  assign wr      = bus_ack & wb_we_i;
  assign wr_loss = wr & (wb_adr_i == REG_LOSS_CNT);
  assign wr_ctrl = wr & (wb_adr_i == REG_CTRL);
  assign wr_irq  = wr & (wb_adr_i == REG_IRQ);
  assign recover = wr_ctrl & wb_dat_i[CTRL_RECOVER];
  assign unused_dat = ^wb_dat_i[31:3];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_irq = 1'b0;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (all_lk) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!all_lk) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!all_lk) begin
          state_d = ST_FAULT;
          set_irq = 1'b1;
        end
      end
      ST_FAULT: begin
        if (AUTO_RECOVER != 0 || recover) begin
          state_d = ST_WAIT_LOCK;
        end
      end
    endcase
  end

  always_comb begin
    ready_d  = (state_d == ST_RUN);
    ack_d    = wb_cyc_i & wb_stb_i & ~ack_q;
    irq_d    = irq_q;
    irq_en_d = irq_en_q;
    hold_d   = hold_q;
    if (wr_irq && wb_dat_i[0]) begin
      irq_d = 1'b0;
    end
    if (set_irq) begin
      irq_d = 1'b1;
    end
    if (wr_ctrl) begin
      irq_en_d = wb_dat_i[CTRL_IRQ_EN];
      hold_d   = wb_dat_i[CTRL_FORCE_HOLD];
    end
  end

  // A clear coinciding with a loss leaves a count of one.
  always_comb begin
    loss_d = loss_q;
    for (int i = 0; i < N_LOCK; i++) begin
      if (wr_loss) begin
        loss_d[i] = {7'd0, fall[i]};
      end else if (fall[i]) begin
        loss_d[i] = sat_inc8(loss_q[i]);
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (wb_adr_i)
      REG_STATUS: begin
        rdata[N_LOCK-1:0] = lk;
        rdata[9:8]        = state_q;
        rdata[16]         = ready_q;
      end
      REG_LOSS_CNT: begin
        for (int i = 0; i < N_LOCK; i++) begin
          rdata[8*i +: 8] = loss_q[i];
        end
      end
      REG_CTRL: begin
        rdata[CTRL_IRQ_EN]     = irq_en_q;
        rdata[CTRL_FORCE_HOLD] = hold_q;
      end
      REG_IRQ: begin
        rdata[0] = irq_q;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_WAIT_LOCK;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      hold_q   <= 1'b0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
      hold_q   <= hold_d;
      loss_q   <= loss_d;
    end
  end

  assign wb_ack_o    = bus_ack;
  assign wb_dat_o    = bus_ack ? rdata : 32'd0;
  assign sys_ready_o = ready_q;
  assign ddr2_hold_o = (state_q != ST_RUN) | hold_q;
  assign irq_o       = irq_q & irq_en_q;

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Bench for clk_lock_monitor: directed scenarios plus
// random lock/bus traffic against a cycle-stamped model.
module tb_clk_lock_monitor;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  lock;
  logic [1:0]  adr;
  logic [31:0] dat_i;
  logic        we, cyc, stb;
  logic [31:0] dat_o;
  logic        ack, ready, hold, irq;

  always #5 clk = ~clk;

  clk_lock_monitor #(
    .N_LOCK        (3),
    .STABLE_CYCLES (S),
    .AUTO_RECOVER  (0)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .lock_async_i (lock),
    .wb_adr_i     (adr),
    .wb_dat_i     (dat_i),
    .wb_we_i      (we),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_dat_o     (dat_o),
    .wb_ack_o     (ack),
    .sys_ready_o  (ready),
    .ddr2_hold_o  (hold),
    .irq_o        (irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: lk is the raw input two edges late; the
  // mode is 0 wait, 1 settle, 2 run, 3 fault.
  logic [2:0] m_s1 = '0;
  logic [2:0] m_lk = '0;
  logic [2:0] m_prev = '0;
  int m_cnt[3] = '{0, 0, 0};
  int m_mode = 0;
  int m_start = 0;
  int edge_n = 0;
  bit m_flag = 0, m_en = 0, m_force = 0, m_ack = 0;

  function automatic logic [31:0] model_read(
    input logic [1:0] a
  );
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: begin
        r[2:0] = m_lk;
        r[9:8] = 2'(m_mode);
        r[16]  = (m_mode == 2);
      end
      2'd1: r = {8'd0, 8'(m_cnt[2]),
                 8'(m_cnt[1]), 8'(m_cnt[0])};
      2'd2: begin
        r[0] = m_en;
        r[2] = m_force;
      end
      default: r[0] = m_flag;
    endcase
    return r;
  endfunction

  task automatic tick();
    bit vis, wr, all_on, ev, set;
    logic [2:0] n_s1, n_lk, n_prev;
    int n_cnt[3];
    int n_mode, n_start;
    bit n_flag, n_en, n_force, n_ack;
    bit exp_ack;
    vis = m_ack && cyc && stb;
    wr = vis && we;
    all_on = (m_lk == 3'b111);
    set = 0;
    n_s1 = lock;
    n_lk = m_s1;
    n_prev = m_lk;
    n_cnt = m_cnt;
    n_mode = m_mode;
    n_start = m_start;
    n_flag = m_flag;
    n_en = m_en;
    n_force = m_force;
    for (int i = 0; i < 3; i++) begin
      ev = m_prev[i] && !m_lk[i];
      if (wr && adr == 2'd1) n_cnt[i] = ev ? 1 : 0;
      else if (ev) n_cnt[i] = (m_cnt[i] < 255)
                              ? m_cnt[i] + 1 : 255;
    end
    case (m_mode)
      0: if (all_on) begin
        n_mode = 1;
        n_start = edge_n;
      end
      1: if (!all_on) n_mode = 0;
         else if (edge_n - m_start == S) n_mode = 2;
      2: if (!all_on) begin
        n_mode = 3;
        set = 1;
      end
      default: if (wr && adr == 2'd2 && dat_i[1])
                 n_mode = 0;
    endcase
    if (wr && adr == 2'd3 && dat_i[0]) n_flag = 0;
    if (set) n_flag = 1;
    if (wr && adr == 2'd2) begin
      n_en = dat_i[0];
      n_force = dat_i[2];
    end
    n_ack = cyc && stb && !m_ack;
    if (rst) begin
      n_s1 = '0;
      n_lk = '0;
      n_prev = '0;
      n_cnt = '{0, 0, 0};
      n_mode = 0;
      n_flag = 0;
      n_en = 0;
      n_force = 0;
      n_ack = 0;
    end
    @(posedge clk);
    #1;
    m_s1 = n_s1;
    m_lk = n_lk;
    m_prev = n_prev;
    m_cnt = n_cnt;
    m_mode = n_mode;
    m_start = n_start;
    m_flag = n_flag;
    m_en = n_en;
    m_force = n_force;
    m_ack = n_ack;
    edge_n++;
    exp_ack = m_ack && cyc && stb;
    check("ready", 32'(ready), 32'(m_mode == 2));
    check("hold", 32'(hold),
          32'((m_mode != 2) || m_force));
    check("irq", 32'(irq), 32'(m_flag && m_en));
    check("ack", 32'(ack), 32'(exp_ack));
    check("dat", dat_o,
          exp_ack ? model_read(adr) : 32'd0);
  endtask

  task automatic bus(
    input  bit          w,
    input  logic [1:0]  a,
    input  logic [31:0] d,
    output logic [31:0] rd
  );
    int n;
    n = 0;
    cyc = 1;
    stb = 1;
    we = w;
    adr = a;
    dat_i = d;
    tick();
    while (!ack && n < 8) begin
      tick();
      n++;
    end
    if (!ack) check("bus_timeout", 32'd0, 32'd1);
    rd = dat_o;
    tick();
    cyc = 0;
    stb = 0;
    we = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [31:0] rd;
  int lat;
  logic [3:0] pat;

  initial begin
    rst = 1;
    lock = '0;
    adr = '0;
    dat_i = '0;
    we = 0;
    cyc = 0;
    stb = 0;
    ticks(2);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hold", 32'(hold), 32'd1);
    check("rst_dat", dat_o, 32'd0);
    rst = 0;
    tick();

    // Lock-up latency and STATUS in RUN
    lock = 3'b111;
    wait_ready(lat);
    check("ready_latency", lat, 19);
    check("hold_in_run", 32'(hold), 32'd0);
    bus(0, 2'd0, 32'd0, rd);
    check("status_run", rd, 32'h0001_0207);

    // Loss during settle restarts the settle
    rst = 1;
    tick();
    rst = 0;
    ticks(14);
    lock = 3'b101;
    tick();
    lock = 3'b111;
    wait_ready(lat);
    check("resettle_latency", lat, 19);
    bus(0, 2'd1, 32'd0, rd);
    check("loss_settle", rd, 32'h0000_0100);

    // Fault, held until software recover
    bus(1, 2'd2, 32'h1, rd);
    lock = 3'b110;
    tick();
    lock = 3'b111;
    ticks(4);
    check("fault_irq", 32'(irq), 32'd1);
    check("fault_ready", 32'(ready), 32'd0);
    ticks(20);
    bus(0, 2'd0, 32'd0, rd);
    check("fault_hold_state", rd, 32'h0000_0307);
    bus(1, 2'd2, 32'h3, rd);
    wait_ready(lat);
    check("recover_latency", lat, 17);
    bus(0, 2'd2, 32'd0, rd);
    check("ctrl_rd", rd, 32'h1);
    bus(1, 2'd3, 32'h1, rd);
    check("irq_clear", 32'(irq), 32'd0);

    // Saturation, then clear racing a loss
    for (int i = 0; i < 300; i++) begin
      lock = 3'b011;
      tick();
      lock = 3'b111;
      tick();
    end
    ticks(3);
    bus(0, 2'd1, 32'd0, rd);
    check("loss_sat", rd, 32'h00FF_0101);
    lock = 3'b011;
    tick();
    lock = 3'b111;
    bus(1, 2'd1, 32'd0, rd);
    ticks(3);
    bus(0, 2'd1, 32'd0, rd);
    check("clear_vs_loss", rd, 32'h0001_0000);

    // Held strobe acks every other cycle
    cyc = 1;
    stb = 1;
    we = 0;
    adr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat[i] = ack;
    end
    cyc = 0;
    stb = 0;
    tick();
    check("ack_pattern", 32'(pat), 32'h5);

    // Abort during the ack cycle: no ack, no write
    cyc = 1;
    stb = 1;
    we = 1;
    adr = 2'd2;
    dat_i = 32'h4;
    tick();
    cyc = 0;
    stb = 0;
    #1;
    check("abort_ack", 32'(ack), 32'd0);
    we = 0;
    tick();
    bus(0, 2'd2, 32'd0, rd);
    check("abort_nowrite", rd, 32'h1);

    // Forced hold in RUN, then reset from RUN
    bus(1, 2'd2, 32'h3, rd);
    wait_ready(lat);
    check("recover2_latency", lat, 17);
    bus(1, 2'd2, 32'h5, rd);
    check("force_hold", 32'(hold), 32'd1);
    check("force_ready", 32'(ready), 32'd1);
    rst = 1;
    tick();
    check("rst_run_ready", 32'(ready), 32'd0);
    check("rst_run_hold", 32'(hold), 32'd1);
    check("rst_run_irq", 32'(irq), 32'd0);
    rst = 0;
    bus(0, 2'd1, 32'd0, rd);
    check("rst_loss", rd, 32'd0);
    bus(0, 2'd2, 32'd0, rd);
    check("rst_ctrl", rd, 32'd0);

    // Random traffic against the model
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst = 1;
        tick();
        rst = 0;
      end else if (r < 110) begin
        lock = 3'b111;
        ticks($urandom_range(1, 30));
      end else if (r < 140) begin
        lock = 3'($urandom_range(0, 7));
        ticks($urandom_range(1, 3));
      end else if (r < 185) begin
        bus(1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            $urandom, rd);
      end else begin
        cyc = 1;
        stb = 1;
        we = 1'($urandom_range(0, 1));
        adr = 2'($urandom_range(0, 3));
        dat_i = $urandom;
        tick();
        cyc = 0;
        stb = 0;
        we = 0;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
